// File: rtl/rv32i_pkg.sv
// Shared RV32I execute-stage definitions: widths, ALU opcode encodings, FSM states.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // {funct7[5], funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WB    = 2'd2
  } exec_state_t;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational RV32I ALU; shifts here are the single-cycle barrel form.
module alu_comb
  import rv32i_pkg::*;
#(
  parameter int XLEN = rv32i_pkg::XLEN
) (
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic [3:0]      i_alu_op,
  output logic [XLEN-1:0] o_result
);

  logic [4:0] w_shamt;

  assign w_shamt = i_op_b[4:0];

  always_comb begin
    o_result = '0;
    case (i_alu_op)
      ALU_ADD:  o_result = i_op_a + i_op_b;
      ALU_SUB:  o_result = i_op_a - i_op_b;
      ALU_SLL:  o_result = i_op_a << w_shamt;
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_op_a < i_op_b)};
      ALU_XOR:  o_result = i_op_a ^ i_op_b;
      ALU_SRL:  o_result = i_op_a >> w_shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_op_a) >>> w_shamt);
      ALU_OR:   o_result = i_op_a | i_op_b;
      ALU_AND:  o_result = i_op_a & i_op_b;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// RV32I execute stage: single-cycle ALU ops plus an optional bit-serial shifter,
// returning a registered write-back (reg_write/rd/rslt_data) to the register file.
module alu_exec_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN         = rv32i_pkg::XLEN,
  parameter int REG_ADDR_W   = rv32i_pkg::REG_ADDR_W,
  parameter int SERIAL_SHIFT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       a1,
  input  logic [XLEN-1:0]       a2,
  input  logic [XLEN-1:0]       imm,
  input  logic                  use_imm,
  input  logic [3:0]            alu_op,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  wb_en_in,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       rslt_data,
  output logic                  busy
);

  exec_state_t           r_state;
  logic [XLEN-1:0]       r_work;
  logic [4:0]            r_cnt;
  logic [3:0]            r_shift_op;
  logic [REG_ADDR_W-1:0] r_rd_pend;
  logic                  r_wb_pend;
  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_rslt;

  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu_result;
  logic [XLEN-1:0] w_step;
  logic [4:0]      w_shamt;
  logic            w_is_shift;
  logic            w_accept;
  logic            w_start_shift;

  assign w_op_b        = use_imm ? imm : a2;
  assign w_shamt       = w_op_b[4:0];
  assign w_is_shift    = (alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA);
  assign w_accept      = in_valid && (r_state != SHIFT);
  assign w_start_shift = (SERIAL_SHIFT != 0) && w_is_shift && (w_shamt != 5'd0);

  alu_comb #(.XLEN(XLEN)) u_alu_comb (
    .i_op_a   (a1),
    .i_op_b   (w_op_b),
    .i_alu_op (alu_op),
    .o_result (w_alu_result)
  );

  // One-bit step of the serial shifter; SRA replicates the sign bit.
  always_comb begin
    w_step = r_work;
    case (r_shift_op)
      ALU_SLL: w_step = {r_work[XLEN-2:0], 1'b0};
      ALU_SRL: w_step = {1'b0, r_work[XLEN-1:1]};
      default: w_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_shift_op  <= '0;
      r_rd_pend   <= '0;
      r_wb_pend   <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_rslt      <= '0;
    end else begin
      r_reg_write <= 1'b0;
      case (r_state)
        SHIFT: begin
          r_work <= w_step;
          r_cnt  <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state     <= WB;
            r_rslt      <= w_step;
            r_rd        <= r_rd_pend;
            r_reg_write <= r_wb_pend && (r_rd_pend != '0);
          end
        end
        default: begin
          // IDLE and WB both accept; rd/rslt_data only change when an op completes.
          if (w_accept) begin
            if (w_start_shift) begin
              r_state    <= SHIFT;
              r_work     <= a1;
              r_cnt      <= w_shamt;
              r_shift_op <= alu_op;
              r_rd_pend  <= rd_in;
              r_wb_pend  <= wb_en_in;
            end else begin
              r_state     <= WB;
              r_rslt      <= w_alu_result;
              r_rd        <= rd_in;
              r_reg_write <= wb_en_in && (rd_in != '0);
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = (r_state != SHIFT);
  assign busy      = (r_state == SHIFT);
  assign reg_write = r_reg_write;
  assign rd        = r_rd;
  assign rslt_data = r_rslt;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: one task per scenario, hand-computed expectations.
module tb_alu_exec_stage;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a1, a2, imm;
  logic        use_imm;
  logic [3:0]  alu_op;
  logic [4:0]  rd_in;
  logic        wb_en_in;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] rslt_data;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a1        (a1),
    .a2        (a2),
    .imm       (imm),
    .use_imm   (use_imm),
    .alu_op    (alu_op),
    .rd_in     (rd_in),
    .wb_en_in  (wb_en_in),
    .reg_write (reg_write),
    .rd        (rd),
    .rslt_data (rslt_data),
    .busy      (busy)
  );

  // Present one op at a negedge and drop in_valid just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] vi, input logic ui, input logic [4:0] vrd, input logic vwb);
    @(negedge clk);
    alu_op = op; a1 = va; a2 = vb; imm = vi; use_imm = ui; rd_in = vrd; wb_en_in = vwb;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total_cnt++;
    if (reg_write !== 1'b0 || rd !== 5'd0 || rslt_data !== 32'd0 || busy !== 1'b0) begin
      $display("FAIL reset_state: rw=%b rd=%0d rslt=%h busy=%b, want 0/0/0/0", reg_write, rd, rslt_data, busy);
    end else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_add;
    send(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 1'b1);
    @(negedge clk);
    total_cnt++;
    if (reg_write !== 1'b1 || rd !== 5'd3 || rslt_data !== 32'd12) begin
      $display("FAIL add: rw=%b rd=%0d rslt=%h, want 1/3/0000000c", reg_write, rd, rslt_data);
    end else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (reg_write !== 1'b0) $display("FAIL add_pulse: rw=%b want 0", reg_write);
    else pass_cnt++;
  endtask

  task automatic test_arith;
    logic [3:0]  ops [7];
    logic [31:0] va  [7];
    logic [31:0] vb  [7];
    logic [31:0] exp_r [7];
    ops[0] = ALU_SUB;  va[0] = 32'h0;        vb[0] = 32'h1;        exp_r[0] = 32'hFFFF_FFFF;
    ops[1] = ALU_SLT;  va[1] = 32'hFFFF_FFFF; vb[1] = 32'h1;       exp_r[1] = 32'h1;
    ops[2] = ALU_SLTU; va[2] = 32'hFFFF_FFFF; vb[2] = 32'h1;       exp_r[2] = 32'h0;
    ops[3] = ALU_OR;   va[3] = 32'h0000_F0F0; vb[3] = 32'h0000_0F0F; exp_r[3] = 32'h0000_FFFF;
    ops[4] = ALU_AND;  va[4] = 32'hFF00_FF00; vb[4] = 32'h0FF0_0FF0; exp_r[4] = 32'h0F00_0F00;
    ops[5] = ALU_ADD;  va[5] = 32'hFFFF_FFFF; vb[5] = 32'h2;       exp_r[5] = 32'h1;
    ops[6] = 4'b1010;  va[6] = 32'h1234_5678; vb[6] = 32'h1;       exp_r[6] = 32'h0;
    for (int i = 0; i < 7; i++) begin
      send(ops[i], va[i], vb[i], 32'd0, 1'b0, 5'd5, 1'b1);
      @(negedge clk);
      total_cnt++;
      if (reg_write !== 1'b1 || rd !== 5'd5 || rslt_data !== exp_r[i]) begin
        $display("FAIL arith[%0d] op=%b: rw=%b rd=%0d rslt=%h, want 1/5/%h", i, ops[i], reg_write, rd, rslt_data, exp_r[i]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_serial_sra;
    send(ALU_SRA, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 5'd7, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || reg_write !== 1'b0) begin
        $display("FAIL sra_shift_cycle%0d: ready=%b busy=%b rw=%b, want 0/1/0", k, in_ready, busy, reg_write);
      end else pass_cnt++;
      // A competing op presented during SHIFT must be ignored.
      if (k == 1) begin
        alu_op = ALU_ADD; a1 = 32'd100; a2 = 32'd1; use_imm = 1'b0; rd_in = 5'd9; wb_en_in = 1'b1;
        in_valid = 1'b1;
      end else if (k == 4) begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    total_cnt++;
    if (reg_write !== 1'b1 || rd !== 5'd7 || rslt_data !== 32'hF800_0000 || busy !== 1'b0) begin
      $display("FAIL sra_result: rw=%b rd=%0d rslt=%h busy=%b, want 1/7/f8000000/0", reg_write, rd, rslt_data, busy);
    end else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (reg_write !== 1'b0 || rd !== 5'd7 || rslt_data !== 32'hF800_0000) begin
      $display("FAIL sra_no_rogue: rw=%b rd=%0d rslt=%h, want 0/7/f8000000", reg_write, rd, rslt_data);
    end else pass_cnt++;
  endtask

  task automatic test_x0_and_back_to_back;
    logic [31:0] xa [3];
    logic [31:0] xb [3];
    logic [31:0] xr [3];
    xa[0] = 32'h0000_00F0; xb[0] = 32'h0000_000F; xr[0] = 32'h0000_00FF;
    xa[1] = 32'hFFFF_0000; xb[1] = 32'h0F0F_0F0F; xr[1] = 32'hF0F0_0F0F;
    xa[2] = 32'h1234_5678; xb[2] = 32'h1234_5678; xr[2] = 32'h0;
    send(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total_cnt++;
      if (reg_write !== 1'b0) $display("FAIL x0_cycle%0d: rw=%b want 0", k, reg_write);
      else pass_cnt++;
    end
    @(negedge clk);
    alu_op = ALU_XOR; a1 = xa[0]; a2 = xb[0]; use_imm = 1'b0; rd_in = 5'd1; wb_en_in = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (reg_write !== 1'b1 || rd !== 5'(i + 1) || rslt_data !== xr[i]) begin
        $display("FAIL b2b[%0d]: rw=%b rd=%0d rslt=%h, want 1/%0d/%h", i, reg_write, rd, rslt_data, i + 1, xr[i]);
      end else pass_cnt++;
      if (i < 2) begin
        a1 = xa[i+1]; a2 = xb[i+1]; rd_in = 5'(i + 2);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    total_cnt++;
    if (reg_write !== 1'b0) $display("FAIL b2b_end: rw=%b want 0", reg_write);
    else pass_cnt++;
  endtask

  task automatic test_sll_bounds;
    int cycles;
    // imm=0x3F: only bits [4:0] form the shift amount (31).
    send(ALU_SLL, 32'h1, 32'd0, 32'h3F, 1'b1, 5'd4, 1'b1);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (reg_write !== 1'b1 && cycles < 40);
    total_cnt++;
    if (cycles !== 32 || rslt_data !== 32'h8000_0000 || rd !== 5'd4) begin
      $display("FAIL sll31: latency=%0d rslt=%h rd=%0d, want 32/80000000/4", cycles, rslt_data, rd);
    end else pass_cnt++;
    send(ALU_SLL, 32'h0000_ABCD, 32'd0, 32'h20, 1'b1, 5'd6, 1'b1);
    @(negedge clk);
    total_cnt++;
    if (reg_write !== 1'b1 || rd !== 5'd6 || rslt_data !== 32'h0000_ABCD || busy !== 1'b0) begin
      $display("FAIL sll0: rw=%b rd=%0d rslt=%h busy=%b, want 1/6/0000abcd/0", reg_write, rd, rslt_data, busy);
    end else pass_cnt++;
  endtask

  task automatic test_reset_abort;
    int pulses;
    send(ALU_SRL, 32'h0000_FF00, 32'd0, 32'd8, 1'b1, 5'd8, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (reg_write !== 1'b0 || rd !== 5'd0 || rslt_data !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL abort_outputs: rw=%b rd=%0d rslt=%h busy=%b ready=%b, want 0/0/0/0/1",
               reg_write, rd, rslt_data, busy, in_ready);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (reg_write === 1'b1) pulses++;
    end
    total_cnt++;
    if (pulses !== 0 || rslt_data !== 32'd0) $display("FAIL abort_no_wb: pulses=%0d rslt=%h, want 0/0", pulses, rslt_data);
    else pass_cnt++;
    send(ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 1'b0, 5'd2, 1'b1);
    @(negedge clk);
    total_cnt++;
    if (reg_write !== 1'b1 || rd !== 5'd2 || rslt_data !== 32'h0F00_0F00) begin
      $display("FAIL after_abort: rw=%b rd=%0d rslt=%h, want 1/2/0f000f00", reg_write, rd, rslt_data);
    end else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a1 = '0; a2 = '0; imm = '0; use_imm = 1'b0;
    alu_op = '0; rd_in = '0; wb_en_in = 1'b0;
    test_reset();
    test_add();
    test_arith();
    test_serial_sra();
    test_x0_and_back_to_back();
    test_sll_bounds();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
